// File: rtl/pkt_len_meter.sv
// pkt_len_meter
//
// Measures the byte length of each packet on a beat-oriented stream and
// emits one {flow, size, enable} record per well-formed packet, lined up to
// drive the per-flow statistics RAM (rx_flow_num_i / pkt_size_i /
// pkt_size_en_i) directly. Malformed framing is dropped and counted.
//
// Ports:
//   clk_i          single clock, rising edge
//   rst_i          asynchronous, active-low reset
//   valid_i        beat valid; every other stream input is ignored when low
//   sop_i          first beat of a packet
//   eop_i          last beat of a packet
//   empty_i        unused bytes in the eop beat (ignored unless eop_i)
//   flow_num_i     flow tag, sampled only on a valid sop beat
//   rx_flow_num_o  flow of the reported packet
//   pkt_size_o     packet length in bytes, saturating at 16'hFFFF
//   pkt_size_en_o  one-cycle record-valid pulse, one cycle after the eop beat
//   err_cnt_o      saturating count of malformed events
//
// Stream handshake: there is no backpressure. A beat is transferred on any
// rising edge where valid_i is high; the meter always accepts it.
//
// Malformed events counted in err_cnt_o:
//   - a non-sop beat arriving while no packet is open (orphan beat)
//   - a sop beat arriving while a packet is open (missing eop); the open
//     packet is dropped and the sop beat starts a new packet as usual.

module pkt_len_meter #(
    parameter int A_WIDTH    = 10,
    parameter int DATA_BYTES = 8,
    localparam int EMPTY_W   = $clog2(DATA_BYTES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               sop_i,
    input  logic               eop_i,
    input  logic [EMPTY_W-1:0] empty_i,
    input  logic [A_WIDTH-1:0] flow_num_i,
    output logic [A_WIDTH-1:0] rx_flow_num_o,
    output logic [15:0]        pkt_size_o,
    output logic               pkt_size_en_o,
    output logic [15:0]        err_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    localparam logic [16:0] BEAT_BYTES = 17'(DATA_BYTES);

    state_t             state_q, state_n;
    logic [16:0]        acc_q, acc_n;
    logic [A_WIDTH-1:0] flow_q, flow_n;

    logic               emit;
    logic [15:0]        emit_size;
    logic [A_WIDTH-1:0] emit_flow;
    logic               err_inc;

    logic [16:0]        empty_ext;

    // Any 17-bit sum above 16'hFFFF is clamped. The accumulator never holds
    // more than 16'hFFFF, so acc + DATA_BYTES - empty always fits in 17 bits
    // and a clamped accumulator keeps reporting 16'hFFFF.
    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

    assign empty_ext = {{(17 - EMPTY_W){1'b0}}, empty_i};

    // Next-state, accumulator and emit decode.
    always_comb begin
        state_n   = state_q;
        acc_n     = acc_q;
        flow_n    = flow_q;
        emit      = 1'b0;
        emit_size = 16'h0000;
        emit_flow = flow_q;
        err_inc   = 1'b0;

        if (valid_i) begin
            if (sop_i) begin
                // A sop while a packet is open aborts it; the beat itself is
                // then treated exactly like a sop seen in IDLE.
                if (state_q == PKT) begin
                    err_inc = 1'b1;
                end
                if (eop_i) begin
                    emit      = 1'b1;
                    emit_size = sat16(BEAT_BYTES - empty_ext);
                    emit_flow = flow_num_i;
                    state_n   = IDLE;
                    acc_n     = 17'd0;
                end else begin
                    flow_n    = flow_num_i;
                    acc_n     = BEAT_BYTES;
                    state_n   = PKT;
                end
            end else if (state_q == IDLE) begin
                // Orphan beat: nothing is open, so it cannot be measured.
                err_inc = 1'b1;
            end else if (eop_i) begin
                emit      = 1'b1;
                emit_size = sat16(acc_q + BEAT_BYTES - empty_ext);
                emit_flow = flow_q;
                state_n   = IDLE;
                acc_n     = 17'd0;
            end else begin
                acc_n = {1'b0, sat16(acc_q + BEAT_BYTES)};
            end
        end
    end

    // FSM and packet context.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            acc_q   <= 17'd0;
            flow_q  <= '0;
        end else begin
            state_q <= state_n;
            acc_q   <= acc_n;
            flow_q  <= flow_n;
        end
    end

    // Record outputs: the enable pulses for one cycle, flow/size hold their
    // last reported values in between.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pkt_size_en_o <= 1'b0;
            pkt_size_o    <= 16'h0000;
            rx_flow_num_o <= '0;
        end else begin
            pkt_size_en_o <= emit;
            if (emit) begin
                pkt_size_o    <= emit_size;
                rx_flow_num_o <= emit_flow;
            end
        end
    end

    // Error counter, saturating.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_cnt_o <= 16'h0000;
        end else if (err_inc && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_pkt_len_meter.sv
// Directed bench for pkt_len_meter with DATA_BYTES=8, A_WIDTH=10.
// Inputs change on the falling edge; outputs are checked 1 time unit after
// the rising edge that consumes a beat, and pulses are tallied on the
// falling edge.

module tb_pkt_len_meter;

    localparam int A_WIDTH    = 10;
    localparam int DATA_BYTES = 8;
    localparam int EMPTY_W    = $clog2(DATA_BYTES);

    logic               clk_i;
    logic               rst_i;
    logic               valid_i;
    logic               sop_i;
    logic               eop_i;
    logic [EMPTY_W-1:0] empty_i;
    logic [A_WIDTH-1:0] flow_num_i;
    logic [A_WIDTH-1:0] rx_flow_num_o;
    logic [15:0]        pkt_size_o;
    logic               pkt_size_en_o;
    logic [15:0]        err_cnt_o;

    int n_cmp;
    int n_err;
    int pulse_cnt;

    pkt_len_meter #(
        .A_WIDTH    (A_WIDTH),
        .DATA_BYTES (DATA_BYTES)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .sop_i         (sop_i),
        .eop_i         (eop_i),
        .empty_i       (empty_i),
        .flow_num_i    (flow_num_i),
        .rx_flow_num_o (rx_flow_num_o),
        .pkt_size_o    (pkt_size_o),
        .pkt_size_en_o (pkt_size_en_o),
        .err_cnt_o     (err_cnt_o)
    );

    // ---------------- clock ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Pulse tally, sampled mid-cycle.
    initial pulse_cnt = 0;
    always @(negedge clk_i) begin
        if (pkt_size_en_o === 1'b1) pulse_cnt = pulse_cnt + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic beat(input logic s, input logic e,
                        input logic [EMPTY_W-1:0] emp,
                        input logic [A_WIDTH-1:0] flow);
        @(negedge clk_i);
        valid_i    = 1'b1;
        sop_i      = s;
        eop_i      = e;
        empty_i    = emp;
        flow_num_i = flow;
        @(posedge clk_i);
        #1;
    endtask

    // Idle cycles; framing inputs are set to junk to show they are ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            valid_i    = 1'b0;
            sop_i      = 1'b1;
            eop_i      = 1'b1;
            empty_i    = EMPTY_W'(7);
            flow_num_i = A_WIDTH'(1023);
            @(posedge clk_i);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i      = 1'b0;
        valid_i    = 1'b0;
        sop_i      = 1'b0;
        eop_i      = 1'b0;
        empty_i    = '0;
        flow_num_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (pkt_size_en_o !== 1'b0) begin n_err++; $display("FAIL reset_en: got %b want 0", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'h0) begin n_err++; $display("FAIL reset_size: got %h want 0000", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd0) begin n_err++; $display("FAIL reset_flow: got %0d want 0", rx_flow_num_o); end
        n_cmp++; if (err_cnt_o !== 16'h0) begin n_err++; $display("FAIL reset_err: got %0d want 0", err_cnt_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        idle(2);
    endtask

    task automatic test_single();
        beat(1'b1, 1'b1, 3'd3, 10'd5);
        n_cmp++; if (pkt_size_en_o !== 1'b1) begin n_err++; $display("FAIL single_en: got %b want 1", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'd5) begin n_err++; $display("FAIL single_size: got %0d want 5", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd5) begin n_err++; $display("FAIL single_flow: got %0d want 5", rx_flow_num_o); end
        idle(1);
        n_cmp++; if (pkt_size_en_o !== 1'b0) begin n_err++; $display("FAIL single_en_low: got %b want 0", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'd5) begin n_err++; $display("FAIL single_size_hold: got %0d want 5", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd5) begin n_err++; $display("FAIL single_flow_hold: got %0d want 5", rx_flow_num_o); end
    endtask

    task automatic test_multi();
        int p0;
        p0 = pulse_cnt;
        beat(1'b1, 1'b0, 3'd5, 10'd9);
        n_cmp++; if (pkt_size_en_o !== 1'b0) begin n_err++; $display("FAIL multi_sop_en: got %b want 0", pkt_size_en_o); end
        beat(1'b0, 1'b0, 3'd6, 10'd9);
        beat(1'b0, 1'b1, 3'd0, 10'd9);
        n_cmp++; if (pkt_size_en_o !== 1'b1) begin n_err++; $display("FAIL multi_en: got %b want 1", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'd24) begin n_err++; $display("FAIL multi_size: got %0d want 24", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd9) begin n_err++; $display("FAIL multi_flow: got %0d want 9", rx_flow_num_o); end
        idle(1);
        n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL multi_pulses: got %0d want 1", pulse_cnt - p0); end
        n_cmp++; if (err_cnt_o !== 16'd0) begin n_err++; $display("FAIL multi_err: got %0d want 0", err_cnt_o); end
    endtask

    task automatic test_gaps();
        int p0;
        p0 = pulse_cnt;
        beat(1'b1, 1'b0, 3'd0, 10'd9);
        idle(2);
        beat(1'b0, 1'b0, 3'd2, 10'd12);
        idle(2);
        beat(1'b0, 1'b1, 3'd0, 10'd13);
        n_cmp++; if (pkt_size_en_o !== 1'b1) begin n_err++; $display("FAIL gaps_en: got %b want 1", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'd24) begin n_err++; $display("FAIL gaps_size: got %0d want 24", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd9) begin n_err++; $display("FAIL gaps_flow: got %0d want 9", rx_flow_num_o); end
        idle(2);
        n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL gaps_pulses: got %0d want 1", pulse_cnt - p0); end
    endtask

    task automatic test_abort();
        int p0;
        p0 = pulse_cnt;
        beat(1'b1, 1'b0, 3'd0, 10'd1);
        beat(1'b0, 1'b0, 3'd0, 10'd1);
        beat(1'b1, 1'b1, 3'd4, 10'd2);
        n_cmp++; if (pkt_size_en_o !== 1'b1) begin n_err++; $display("FAIL abort_en: got %b want 1", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'd4) begin n_err++; $display("FAIL abort_size: got %0d want 4", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd2) begin n_err++; $display("FAIL abort_flow: got %0d want 2", rx_flow_num_o); end
        n_cmp++; if (err_cnt_o !== 16'd1) begin n_err++; $display("FAIL abort_err: got %0d want 1", err_cnt_o); end
        idle(1);
        n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL abort_pulses: got %0d want 1", pulse_cnt - p0); end
    endtask

    task automatic test_orphan();
        int p0;
        p0 = pulse_cnt;
        beat(1'b0, 1'b0, 3'd0, 10'd20);
        beat(1'b0, 1'b1, 3'd1, 10'd21);
        idle(1);
        n_cmp++; if (err_cnt_o !== 16'd3) begin n_err++; $display("FAIL orphan_err: got %0d want 3", err_cnt_o); end
        n_cmp++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL orphan_pulses: got %0d want 0", pulse_cnt - p0); end
        beat(1'b1, 1'b1, 3'd0, 10'd7);
        n_cmp++; if (pkt_size_en_o !== 1'b1) begin n_err++; $display("FAIL orphan_next_en: got %b want 1", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'd8) begin n_err++; $display("FAIL orphan_next_size: got %0d want 8", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd7) begin n_err++; $display("FAIL orphan_next_flow: got %0d want 7", rx_flow_num_o); end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = pulse_cnt;
        beat(1'b1, 1'b1, 3'd1, 10'd100);
        n_cmp++; if (pkt_size_en_o !== 1'b1) begin n_err++; $display("FAIL b2b_en0: got %b want 1", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'd7) begin n_err++; $display("FAIL b2b_size0: got %0d want 7", pkt_size_o); end
        beat(1'b1, 1'b1, 3'd2, 10'd200);
        n_cmp++; if (pkt_size_en_o !== 1'b1) begin n_err++; $display("FAIL b2b_en1: got %b want 1", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'd6) begin n_err++; $display("FAIL b2b_size1: got %0d want 6", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd200) begin n_err++; $display("FAIL b2b_flow1: got %0d want 200", rx_flow_num_o); end
        idle(1);
        n_cmp++; if (pulse_cnt - p0 !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - p0); end
        n_cmp++; if (err_cnt_o !== 16'd3) begin n_err++; $display("FAIL b2b_err: got %0d want 3", err_cnt_o); end
    endtask

    // 8200 beats * 8 bytes = 65600 > 65535, so the report clamps.
    task automatic test_saturate();
        int p0;
        p0 = pulse_cnt;
        beat(1'b1, 1'b0, 3'd0, 10'd33);
        for (int i = 0; i < 8198; i++) beat(1'b0, 1'b0, 3'd0, 10'd0);
        beat(1'b0, 1'b1, 3'd0, 10'd0);
        n_cmp++; if (pkt_size_en_o !== 1'b1) begin n_err++; $display("FAIL sat_en: got %b want 1", pkt_size_en_o); end
        n_cmp++; if (pkt_size_o !== 16'hFFFF) begin n_err++; $display("FAIL sat_size: got %h want ffff", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd33) begin n_err++; $display("FAIL sat_flow: got %0d want 33", rx_flow_num_o); end
        idle(1);
        n_cmp++; if (pulse_cnt - p0 !== 1) begin n_err++; $display("FAIL sat_pulses: got %0d want 1", pulse_cnt - p0); end
    endtask

    task automatic test_reset_mid();
        int p0;
        beat(1'b1, 1'b0, 3'd0, 10'd44);
        beat(1'b0, 1'b0, 3'd0, 10'd44);
        @(negedge clk_i);
        valid_i = 1'b0;
        rst_i   = 1'b0;
        #1;
        n_cmp++; if (err_cnt_o !== 16'd0) begin n_err++; $display("FAIL rstmid_err_clr: got %0d want 0", err_cnt_o); end
        n_cmp++; if (pkt_size_o !== 16'd0) begin n_err++; $display("FAIL rstmid_size_clr: got %0d want 0", pkt_size_o); end
        n_cmp++; if (rx_flow_num_o !== 10'd0) begin n_err++; $display("FAIL rstmid_flow_clr: got %0d want 0", rx_flow_num_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        p0 = pulse_cnt;
        beat(1'b0, 1'b1, 3'd2, 10'd44);
        n_cmp++; if (pkt_size_en_o !== 1'b0) begin n_err++; $display("FAIL rstmid_en: got %b want 0", pkt_size_en_o); end
        idle(1);
        n_cmp++; if (err_cnt_o !== 16'd1) begin n_err++; $display("FAIL rstmid_err: got %0d want 1", err_cnt_o); end
        n_cmp++; if (pulse_cnt - p0 !== 0) begin n_err++; $display("FAIL rstmid_pulses: got %0d want 0", pulse_cnt - p0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_multi();
        test_gaps();
        test_abort();
        test_orphan();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
